seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised N-digit multiplexed 7-segment driver. Accepts a binary value over a
//  valid/ready handshake and converts it to BCD with a sequential double-dabble
//  (one shift per clock). It holds the last completed result in a display register and
//  time-multiplexes the digits with a programmable refresh prescaler.
//  Used as a drop-in display back-end for any board-level top with a multiplexed display.
// PARAMETERS
//  BIN_W          16     binary input width (>=4)
//  N_DIG          5      number of digits driven (>=2); digit 0 = least significant
//  CLK_DIV        50000  clk cycles per digit slot (>=2)
//  SEG_ACTIVE_LOW 0      1: invert abcdefg at the output
//  EN_ACTIVE_LOW  0      1: invert dig_en at the output
// PORTS
//  clk      in   1       system clock, rising edge
//  rst      in   1       synchronous, active-high reset
//  bin_in   in   BIN_W   value to display; sampled on accept
//  bin_vld  in   1       bin_in valid
//  bin_rdy  out  1       converter idle; accept = bin_vld & bin_rdy at a rising edge
//  abcdefg  out  7       segments; bit6 = a ... bit0 = g; '0' = 7'b1111110 (active-high)
//  dig_en   out  N_DIG   one-hot digit enable; bit i drives digit i
//  ovf      out  1       displayed value exceeded 10^N_DIG-1
// BEHAVIOUR
//  Reset: bin_rdy=1, display reg=0, ovf=0, prescaler=0, digit index=0.
//   Consequently abcdefg=7'b1111110 and dig_en=1 (polarity params applied).
//  Converter FSM, two states:
//   IDLE: bin_rdy=1. On accept: load shift reg=bin_in, BCD acc=0, bit count=0, ovf_acc=0,
//    then go to CONV.
//   CONV: bin_rdy=0. Each cycle: add 3 to every BCD nibble >=5, then shift left 1.
//    ovf_acc |= bit shifted out of the top nibble.
//    On the BIN_W-th shift: display reg <= acc, ovf <= ovf_acc, then go to IDLE.
//  Latency: display updates exactly BIN_W cycles after the accept edge.
//   bin_rdy is high in the following cycle.
//  bin_vld while busy is ignored (no queueing). The display is never torn mid-conversion.
//  Reset mid-conversion aborts it; the reset values above apply.
//  Scan: prescaler counts 0..CLK_DIV-1 and wraps.
//   At count CLK_DIV-1, the digit index advances by 1, wrapping N_DIG-1 -> 0.
//   Each digit is therefore lit for exactly CLK_DIV cycles.
//  Outputs are combinational from the registered index and display reg:
//   dig_en = 1<<index; abcdefg = decode(display nibble[index]).
//  Decode: nibble 0-9 -> standard glyphs; nibbles 10-15 cannot occur and decode blank.
//  Overflow: while ovf=1 every digit shows '-' (7'b0000001); the BCD nibbles are ignored.
//  Conversion and scanning are independent; a display-reg update takes effect on the
//   currently lit digit immediately.
// CONFIGURATION
//  SEG7_LZB_EN defined: leading-zero blanking.
//   A digit i>0 shows blank (7'b0000000) when it and all higher digits are 0.
//   Digit 0 is never blanked, so the value 0 shows a single '0'.
//   dig_en still scans every digit; ovf overrides blanking.
//  SEG7_LZB_EN undefined: all digits are shown, zeros included.
// STRUCTURE
//  Shared package seg7_pkg:
//   - segment glyph constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
//   - the converter state encoding localparams ST_IDLE, ST_CONV
//   - function clog2 for sizing the prescaler, bit counter and index
//  One sub-module: seg7_dabble_seq (the converter FSM: handshake in, BCD + ovf out).
//  The scan counter, digit mux and decode stay in the top.
// TESTING
//  1 Reset, CLK_DIV=4, N_DIG=5:
//    -> abcdefg=7'b1111110, dig_en=5'b00001, bin_rdy=1.
//    -> dig_en steps 00001->00010 after 4 cycles; 10000 wraps to 00001 after 20 cycles.
//  2 Accept bin_in=16'd65535:
//    -> bin_rdy=0 for 16 cycles; display reg=0x65535 on cycle 16.
//    -> scan then shows 5,3,5,5,6 on digits 0..4; ovf=0.
//  3 N_DIG=4, accept 16'd12345:
//    -> ovf=1 after 16 cycles; all four digits show 7'b0000001.
//    -> then accept 16'd9999: ovf=0, digits show 9999.
//  4 Accept 16'd7 with bin_vld held high through CONV, then change bin_in=16'd99:
//    -> only 7 is converted; 99 is accepted on the first bin_rdy=1 cycle afterwards.
//  5 Assert rst on cycle 8 of a conversion of 16'd4321:
//    -> next cycle bin_rdy=1, display=0, ovf=0; 4321 never appears.
//  6 With SEG7_LZB_EN, accept 16'd42:
//    -> digits 4..2 are blank, digit1='4' (7'b0110011), digit0='2' (7'b1101101).
//    -> accept 0: only digit 0 shows '0'.
//    -> without the macro, 42 shows 00042.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display back-end:
// segment glyphs, converter state encoding and small sizing/decode helpers.
package seg7_pkg;

  // abcdefg order, bit6 = a ... bit0 = g, active-high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_e;

  // Ceiling log2, never below 1 so every counter has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction applied to a BCD nibble before each shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seg7_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Accepts over valid/ready, publishes BCD and an overflow flag when done.
module seg7_dabble_seq
  import seg7_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int N_DIG = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_W-1:0]     bin_in,
  input  logic                 bin_vld,
  output logic                 bin_rdy,
  output logic [4*N_DIG-1:0]   bcd,
  output logic                 ovf
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  conv_state_e        state;
  conv_state_e        state_nxt;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_acc;
  logic               top_bit;
  logic               accept;
  logic               last_shift;

  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < N_DIG; i++) begin
      acc_adj[4*i +: 4] = dabble_adj(acc[4*i +: 4]);
    end
  end

  // The bit leaving the top nibble means the value does not fit in N_DIG digits.
  assign top_bit    = acc_adj[BCD_W-1];
  assign acc_shift  = {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
  assign accept     = bin_vld & bin_rdy;
  assign last_shift = (state == ST_CONV) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    bin_rdy   = 1'b0;
    case (state)
      ST_IDLE: begin
        bin_rdy = 1'b1;
        if (bin_vld) state_nxt = ST_CONV;
      end
      ST_CONV: begin
        if (cnt == CNT_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
      end else if (state == ST_CONV) begin
        cnt <= cnt + 1'b1;
      end
      // Result is only published whole, so the display never sees partial BCD.
      if (last_shift) begin
        bcd <= acc_shift;
        ovf <= ovf_acc | top_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= bin_in;
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (state == ST_CONV) begin
      shreg   <= {shreg[BIN_W-2:0], 1'b0};
      acc     <= acc_shift;
      ovf_acc <= ovf_acc | top_bit;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment driver: BCD conversion, refresh prescaler, digit mux.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int BIN_W          = 16,
  parameter int N_DIG          = 5,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int EN_ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_vld,
  output logic             bin_rdy,
  output logic [6:0]       abcdefg,
  output logic [N_DIG-1:0] dig_en,
  output logic             ovf
);

  localparam int DIV_W = clog2(CLK_DIV);
  localparam int IDX_W = clog2(N_DIG);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  logic [4*N_DIG-1:0] disp;
  logic [DIV_W-1:0]   presc;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         nib;
  logic [N_DIG-1:0]   en_raw;
  logic [6:0]         seg_raw;
  logic               blank;

  seg7_dabble_seq #(
    .BIN_W (BIN_W),
    .N_DIG (N_DIG)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .bin_vld (bin_vld),
    .bin_rdy (bin_rdy),
    .bcd     (disp),
    .ovf     (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == DIV_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    nib    = '0;
    en_raw = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = disp[4*i +: 4];
        en_raw[i] = 1'b1;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic lz_run;

  // Walk down from the top digit; a digit blanks while everything above it is zero.
  always_comb begin
    lz_run = 1'b1;
    blank  = 1'b0;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      lz_run = lz_run && (disp[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) blank = lz_run;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    if (ovf) begin
      seg_raw = SEG_DASH;
    end else if (blank) begin
      seg_raw = SEG_BLANK;
    end else begin
      seg_raw = seg_decode(nib);
    end
  end

  assign abcdefg = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign dig_en  = (EN_ACTIVE_LOW != 0) ? ~en_raw : en_raw;

endmodule
